// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle MIPS-I subset core on one unified req/ack memory port
// Optional MCDP_DEBUG_EN: adds debug_Reg = R[NREGS-1] and a stray-mem_ack assertion.
module multicycle_datapath #(
  parameter int          NREGS    = 32,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              trap
`ifdef MCDP_DEBUG_EN
  ,
  output logic [31:0]       debug_Reg
`endif
);

  localparam int RW = $clog2(NREGS);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t            state_q;
  logic [31:0]       ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              trap_q;
  logic [31:0]       rf_q [NREGS];

  logic [5:0]    op, fn;
  logic [4:0]    shamt;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
  logic [31:0]   simm, pc_ext, jump_tgt, ea, alu_res, wb_data;
  logic          legal, is_ctl;

  assign op       = ir_q[31:26];
  assign fn       = ir_q[5:0];
  assign shamt    = ir_q[10:6];
  assign rs_idx   = ir_q[21 +: RW];
  assign rt_idx   = ir_q[16 +: RW];
  assign rd_idx   = ir_q[11 +: RW];
  assign simm     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext   = 32'(pc_q);
  assign jump_tgt = {pc_ext[31:28], ir_q[25:0], 2'b00};
  assign ea       = a_q + simm;
  assign is_ctl   = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
  assign wb_idx   = (op == OP_R) ? rd_idx : rt_idx;
  assign wb_data  = (op == OP_LW) ? mdr_q : aluout_q;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:    legal = fn inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = a_q + simm;
    if (op == OP_R) begin
      case (fn)
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
        FN_SLL:  alu_res = b_q << shamt;
        FN_SRL:  alu_res = b_q >> shamt;
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  // Request is gated by Reset so an in-flight transfer is dropped the moment reset asserts
  assign mem_req   = Reset && ((state_q == S_FETCH) || (state_q == S_MEM));
  assign mem_we    = (state_q == S_MEM) && (op == OP_SW);
  assign mem_addr  = (state_q == S_MEM) ? aluout_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata = b_q;
  assign pc        = (state_q == S_FETCH) ? pc_q : pc_q - ADDR_W'(4);
  assign trap      = trap_q;
  assign retire    = Reset && ((state_q == S_WB) ||
                               (state_q == S_MEM && op == OP_SW && mem_ack) ||
                               (state_q == S_EXEC && is_ctl));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC[ADDR_W-1:0];
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      trap_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (mem_ack) begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + ADDR_W'(4);
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q      <= rf_q[rs_idx];
          b_q      <= rf_q[rt_idx];
          aluout_q <= pc_ext + {simm[29:0], 2'b00};
          trap_q   <= !legal;
          state_q  <= legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          case (op)
            OP_LW, OP_SW: begin
              aluout_q <= ea;
              trap_q   <= |ea[1:0];
              state_q  <= (|ea[1:0]) ? S_TRAP : S_MEM;
            end
            OP_BEQ: begin
              if (a_q == b_q) pc_q <= aluout_q[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
            OP_BNE: begin
              if (a_q != b_q) pc_q <= aluout_q[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
            OP_J: begin
              pc_q    <= jump_tgt[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
            default: begin
              aluout_q <= alu_res;
              state_q  <= S_WB;
            end
          endcase
        end
        S_MEM: if (mem_ack) begin
          if (op == OP_SW) begin
            state_q <= S_FETCH;
          end else begin
            mdr_q   <= mem_rdata;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (wb_idx != '0) rf_q[wb_idx] <= wb_data;
          state_q <= S_FETCH;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

`ifdef MCDP_DEBUG_EN
  logic [31:0] debug_q;
  assign debug_Reg = debug_q;

  always_ff @(posedge Clk) begin
    if (!Reset) debug_q <= '0;
    else        debug_q <= rf_q[NREGS-1];
  end

  always_ff @(posedge Clk) begin
    if (Reset) assert (mem_req || !mem_ack);
  end
`endif

endmodule
